// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory channel arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } channel_state_t;

  // Width of a consumer index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Increment with an explicit wrap so non-power-of-two counts work.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_channel_arbiter_if.sv
// Requester and memory-side bundle for the channel arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface mem_channel_arbiter_if #(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_channel_arbiter_rr_picker.sv
// Rotating find-first-set: first set bit at or after i_ptr, wrapping.
module rr_picker #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Walk N candidates from the pointer; the first hit wins.
  always_comb begin
    int cand;
    cand    = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(i_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters.
// Each channel runs its own grant/wait/relay FSM with a private rr pointer.
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_channel_arbiter_if.slave bus
);

  localparam int CW    = idx_width(NUM_CONSUMERS);
  localparam bit WR_EN = (WRITE_ENABLE != 0);

  logic [NUM_CONSUMERS-1:0] w_rd_req, w_wr_req, w_req;
  assign w_rd_req = bus.consumer_read_valid;
  assign w_wr_req = WR_EN ? bus.consumer_write_valid : '0;
  assign w_req    = w_rd_req | w_wr_req;

  channel_state_t r_state [NUM_CHANNELS];
  channel_state_t w_state_next [NUM_CHANNELS];
  logic [CW-1:0]  r_cur [NUM_CHANNELS];
  logic [CW-1:0]  w_cur_next [NUM_CHANNELS];
  logic [CW-1:0]  r_ptr [NUM_CHANNELS];
  logic [CW-1:0]  w_ptr_next [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_busy, w_busy_next;

  logic [NUM_CHANNELS-1:0]                r_mrd_valid, w_mrd_valid_next;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] r_mrd_addr, w_mrd_addr_next;
  logic [NUM_CHANNELS-1:0]                r_mwr_valid, w_mwr_valid_next;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] r_mwr_addr, w_mwr_addr_next;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] r_mwr_data, w_mwr_data_next;
  logic [NUM_CONSUMERS-1:0]                r_crd_ready, w_crd_ready_next;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_crd_data, w_crd_data_next;
  logic [NUM_CONSUMERS-1:0]                r_cwr_ready, w_cwr_ready_next;

  logic          w_take [NUM_CHANNELS];
  logic [CW-1:0] w_pick [NUM_CHANNELS];

  // Picker chain: each channel sees requests minus busy owners minus the
  // grants made by lower-numbered channels in this same cycle.
  genvar gi;
  for (gi = 0; gi < NUM_CHANNELS; gi++) begin : gen_ch
    logic [NUM_CONSUMERS-1:0] w_avail;
    logic                     w_found;
    logic [CW-1:0]            w_idx;

    if (gi == 0) begin : gen_head
      assign w_avail = w_req & ~r_busy;
    end else begin : gen_link
      assign w_avail = gen_ch[gi-1].gen_fwd.w_avail_fwd;
    end

    rr_picker #(.N(NUM_CONSUMERS), .W(CW)) u_picker (
      .i_req   (w_avail),
      .i_ptr   (r_ptr[gi]),
      .o_found (w_found),
      .o_idx   (w_idx)
    );

    assign w_take[gi] = w_found && (r_state[gi] == IDLE);
    assign w_pick[gi] = w_idx;

    if (gi < NUM_CHANNELS - 1) begin : gen_fwd
      logic [NUM_CONSUMERS-1:0] w_avail_fwd;
      assign w_avail_fwd = w_take[gi] ? (w_avail & ~(NUM_CONSUMERS'(1) << w_idx)) : w_avail;
    end
  end

  // Per-channel next-state and output-register updates, channels in order.
  always_comb begin
    w_busy_next      = r_busy;
    w_mrd_valid_next = r_mrd_valid;
    w_mrd_addr_next  = r_mrd_addr;
    w_mwr_valid_next = r_mwr_valid;
    w_mwr_addr_next  = r_mwr_addr;
    w_mwr_data_next  = r_mwr_data;
    w_crd_ready_next = r_crd_ready;
    w_crd_data_next  = r_crd_data;
    w_cwr_ready_next = r_cwr_ready;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_state_next[k] = r_state[k];
      w_cur_next[k]   = r_cur[k];
      w_ptr_next[k]   = r_ptr[k];
      case (r_state[k])
        IDLE: begin
          if (w_take[k]) begin
            w_busy_next[w_pick[k]] = 1'b1;
            w_cur_next[k]          = w_pick[k];
            w_ptr_next[k]          = CW'(wrap_inc(int'(w_pick[k]), NUM_CONSUMERS));
            if (w_rd_req[w_pick[k]]) begin
              w_state_next[k]     = READ_WAITING;
              w_mrd_valid_next[k] = 1'b1;
              w_mrd_addr_next[k]  = bus.consumer_read_address[w_pick[k]];
            end else if (WR_EN) begin
              w_state_next[k]     = WRITE_WAITING;
              w_mwr_valid_next[k] = 1'b1;
              w_mwr_addr_next[k]  = bus.consumer_write_address[w_pick[k]];
              w_mwr_data_next[k]  = bus.consumer_write_data[w_pick[k]];
            end
          end
        end
        READ_WAITING: begin
          if (bus.mem_read_ready[k]) begin
            w_crd_data_next[r_cur[k]]  = bus.mem_read_data[k];
            w_crd_ready_next[r_cur[k]] = 1'b1;
            w_mrd_valid_next[k]        = 1'b0;
            w_state_next[k]            = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (bus.mem_write_ready[k]) begin
            w_cwr_ready_next[r_cur[k]] = 1'b1;
            w_mwr_valid_next[k]        = 1'b0;
            w_state_next[k]            = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!w_rd_req[r_cur[k]]) begin
            w_crd_ready_next[r_cur[k]] = 1'b0;
            w_busy_next[r_cur[k]]      = 1'b0;
            w_state_next[k]            = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!w_wr_req[r_cur[k]]) begin
            w_cwr_ready_next[r_cur[k]] = 1'b0;
            w_busy_next[r_cur[k]]      = 1'b0;
            w_state_next[k]            = IDLE;
          end
        end
        default: w_state_next[k] = IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_state[k] <= IDLE;
        r_cur[k]   <= '0;
        r_ptr[k]   <= '0;
      end
      r_busy      <= '0;
      r_mrd_valid <= '0;
      r_mrd_addr  <= '0;
      r_mwr_valid <= '0;
      r_mwr_addr  <= '0;
      r_mwr_data  <= '0;
      r_crd_ready <= '0;
      r_crd_data  <= '0;
      r_cwr_ready <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_state[k] <= w_state_next[k];
        r_cur[k]   <= w_cur_next[k];
        r_ptr[k]   <= w_ptr_next[k];
      end
      r_busy      <= w_busy_next;
      r_mrd_valid <= w_mrd_valid_next;
      r_mrd_addr  <= w_mrd_addr_next;
      r_mwr_valid <= w_mwr_valid_next;
      r_mwr_addr  <= w_mwr_addr_next;
      r_mwr_data  <= w_mwr_data_next;
      r_crd_ready <= w_crd_ready_next;
      r_crd_data  <= w_crd_data_next;
      r_cwr_ready <= w_cwr_ready_next;
    end
  end

  assign bus.mem_read_valid       = r_mrd_valid;
  assign bus.mem_read_address     = r_mrd_addr;
  assign bus.mem_write_valid      = r_mwr_valid;
  assign bus.mem_write_address    = r_mwr_addr;
  assign bus.mem_write_data       = r_mwr_data;
  assign bus.consumer_read_ready  = r_crd_ready;
  assign bus.consumer_read_data   = r_crd_data;
  assign bus.consumer_write_ready = r_cwr_ready;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: a 2-channel and a 1-channel arbiter, 8 consumers each.
module tb_mem_channel_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  mem_channel_arbiter_if #(.NUM_CONSUMERS(8), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8)) bus ();
  mem_channel_arbiter_if #(.NUM_CONSUMERS(8), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8)) bus1 ();

  mem_channel_arbiter #(.NUM_CONSUMERS(8), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8), .WRITE_ENABLE(1)) dut (
    .clk (clk), .reset (rst_n), .bus (bus)
  );
  mem_channel_arbiter #(.NUM_CONSUMERS(8), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8), .WRITE_ENABLE(1)) dut1 (
    .clk (clk), .reset (rst_n), .bus (bus1)
  );

  // Memory for the 2-channel DUT: scripted, or zero-wait returning addr+0x10.
  logic       auto_mem;
  logic [1:0] m_rrdy, m_wrdy;
  logic [7:0] m_rdata [2];
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bus.mem_read_ready[k]  = auto_mem ? bus.mem_read_valid[k] : m_rrdy[k];
      bus.mem_read_data[k]   = auto_mem ? bus.mem_read_address[k] + 8'h10 : m_rdata[k];
      bus.mem_write_ready[k] = auto_mem ? bus.mem_write_valid[k] : m_wrdy[k];
    end
  end

  // Memory for the 1-channel DUT: always zero-wait, data equals address.
  assign bus1.mem_read_ready  = bus1.mem_read_valid;
  assign bus1.mem_read_data   = bus1.mem_read_address;
  assign bus1.mem_write_ready = bus1.mem_write_valid;

  task automatic clear_inputs;
    bus.consumer_read_valid     = '0;
    bus.consumer_read_address   = '0;
    bus.consumer_write_valid    = '0;
    bus.consumer_write_address  = '0;
    bus.consumer_write_data     = '0;
    bus1.consumer_read_valid    = '0;
    bus1.consumer_read_address  = '0;
    bus1.consumer_write_valid   = '0;
    bus1.consumer_write_address = '0;
    bus1.consumer_write_data    = '0;
    auto_mem   = 1'b0;
    m_rrdy     = '0;
    m_wrdy     = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b00) $display("FAIL reset_mrv: got %b want 00", bus.mem_read_valid); else n_pass++;
    n_checks++; if (bus.mem_write_valid !== 2'b00) $display("FAIL reset_mwv: got %b want 00", bus.mem_write_valid); else n_pass++;
    n_checks++; if (bus.consumer_read_ready !== 8'h00) $display("FAIL reset_crr: got %h want 00", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (bus.consumer_write_ready !== 8'h00) $display("FAIL reset_cwr: got %h want 00", bus.consumer_write_ready); else n_pass++;
    n_checks++; if (bus1.mem_read_valid !== 1'b0) $display("FAIL reset_mrv1: got %b want 0", bus1.mem_read_valid); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b00) $display("FAIL idle_mrv: got %b want 00", bus.mem_read_valid); else n_pass++;
  endtask

  task automatic test_single_read;
    do_reset();
    bus.consumer_read_address[3] = 8'h2A;
    bus.consumer_read_valid[3]   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b01) $display("FAIL single_mrv: got %b want 01", bus.mem_read_valid); else n_pass++;
    n_checks++; if (bus.mem_read_address[0] !== 8'h2A) $display("FAIL single_addr: got %h want 2a", bus.mem_read_address[0]); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b01) $display("FAIL single_hold: got %b want 01", bus.mem_read_valid); else n_pass++;
    m_rrdy[0]  = 1'b1;
    m_rdata[0] = 8'h5C;
    @(negedge clk);
    m_rrdy[0]  = 1'b0;
    m_rdata[0] = 8'h00;
    n_checks++; if (bus.consumer_read_ready !== 8'h08) $display("FAIL single_crr: got %h want 08", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (bus.consumer_read_data[3] !== 8'h5C) $display("FAIL single_data: got %h want 5c", bus.consumer_read_data[3]); else n_pass++;
    n_checks++; if (bus.mem_read_valid !== 2'b00) $display("FAIL single_mrv_low: got %b want 00", bus.mem_read_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.consumer_read_ready !== 8'h08) $display("FAIL single_crr_hold: got %h want 08", bus.consumer_read_ready); else n_pass++;
    bus.consumer_read_valid[3] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.consumer_read_ready !== 8'h00) $display("FAIL single_release: got %h want 00", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (dut.r_state[0] !== mem_arb_pkg::IDLE) $display("FAIL single_idle: got %0d want 0", dut.r_state[0]); else n_pass++;
  endtask

  task automatic test_eight_reads;
    logic [7:0] done;
    logic       dup;
    do_reset();
    auto_mem = 1'b1;
    for (int c = 0; c < 8; c++) bus.consumer_read_address[c] = 8'(8'h30 + c);
    bus.consumer_read_valid = 8'hFF;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b11) $display("FAIL eight_mrv: got %b want 11", bus.mem_read_valid); else n_pass++;
    n_checks++; if (bus.mem_read_address[0] !== 8'h30) $display("FAIL eight_addr0: got %h want 30", bus.mem_read_address[0]); else n_pass++;
    n_checks++; if (bus.mem_read_address[1] !== 8'h31) $display("FAIL eight_addr1: got %h want 31", bus.mem_read_address[1]); else n_pass++;
    done = '0;
    dup  = 1'b0;
    for (int cyc = 0; cyc < 100 && !(done == 8'hFF && bus.consumer_read_ready == 8'h00); cyc++) begin
      if (bus.mem_read_valid == 2'b11 && bus.mem_read_address[0] == bus.mem_read_address[1]) dup = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (bus.consumer_read_ready[c] && bus.consumer_read_valid[c]) begin
          n_checks++;
          if (bus.consumer_read_data[c] !== 8'(8'h40 + c))
            $display("FAIL eight_data%0d: got %h want %h", c, bus.consumer_read_data[c], 8'(8'h40 + c));
          else n_pass++;
          done[c] = 1'b1;
          bus.consumer_read_valid[c] = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_checks++; if (done !== 8'hFF) $display("FAIL eight_done: got %h want ff", done); else n_pass++;
    n_checks++; if (dup !== 1'b0) $display("FAIL eight_dup: got %b want 0", dup); else n_pass++;
    n_checks++; if (dut.r_busy !== 8'h00) $display("FAIL eight_busy: got %h want 00", dut.r_busy); else n_pass++;
    n_checks++; if (bus.consumer_read_ready !== 8'h00) $display("FAIL eight_crr: got %h want 00", bus.consumer_read_ready); else n_pass++;
  endtask

  task automatic test_fairness;
    int grants[$];
    int exp_g[4] = '{0, 5, 0, 5};
    do_reset();
    bus1.consumer_read_address[0] = 8'd0;
    bus1.consumer_read_address[5] = 8'd5;
    bus1.consumer_read_valid[0]   = 1'b1;
    bus1.consumer_read_valid[5]   = 1'b1;
    for (int cyc = 0; cyc < 60 && grants.size() < 4; cyc++) begin
      @(negedge clk);
      if (bus1.mem_read_valid[0]) grants.push_back(int'(bus1.mem_read_address[0]));
      for (int c = 0; c < 8; c += 5) begin
        if (bus1.consumer_read_ready[c] && bus1.consumer_read_valid[c]) bus1.consumer_read_valid[c] = 1'b0;
        else if (!bus1.consumer_read_valid[c] && !bus1.consumer_read_ready[c]) bus1.consumer_read_valid[c] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= grants.size()) $display("FAIL rr_grant%0d: got none want %0d", i, exp_g[i]);
      else if (grants[i] != exp_g[i]) $display("FAIL rr_grant%0d: got %0d want %0d", i, grants[i], exp_g[i]);
      else n_pass++;
    end
    bus1.consumer_read_valid = '0;
  endtask

  task automatic test_precedence;
    do_reset();
    auto_mem = 1'b1;
    bus.consumer_read_address[2]  = 8'h11;
    bus.consumer_write_address[2] = 8'h22;
    bus.consumer_write_data[2]    = 8'h33;
    bus.consumer_read_valid[2]    = 1'b1;
    bus.consumer_write_valid[2]   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b01) $display("FAIL prec_mrv: got %b want 01", bus.mem_read_valid); else n_pass++;
    n_checks++; if (bus.mem_write_valid !== 2'b00) $display("FAIL prec_mwv_early: got %b want 00", bus.mem_write_valid); else n_pass++;
    n_checks++; if (bus.mem_read_address[0] !== 8'h11) $display("FAIL prec_raddr: got %h want 11", bus.mem_read_address[0]); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.consumer_read_ready !== 8'h04) $display("FAIL prec_crr: got %h want 04", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (bus.consumer_write_ready !== 8'h00) $display("FAIL prec_cwr_early: got %h want 00", bus.consumer_write_ready); else n_pass++;
    bus.consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_write_valid !== 2'b00) $display("FAIL prec_mwv_hold: got %b want 00", bus.mem_write_valid); else n_pass++;
    n_checks++; if (bus.consumer_read_ready !== 8'h00) $display("FAIL prec_crr_rel: got %h want 00", bus.consumer_read_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.mem_write_valid !== 2'b01) $display("FAIL prec_mwv: got %b want 01", bus.mem_write_valid); else n_pass++;
    n_checks++; if (bus.mem_write_address[0] !== 8'h22) $display("FAIL prec_waddr: got %h want 22", bus.mem_write_address[0]); else n_pass++;
    n_checks++; if (bus.mem_write_data[0] !== 8'h33) $display("FAIL prec_wdata: got %h want 33", bus.mem_write_data[0]); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.consumer_write_ready !== 8'h04) $display("FAIL prec_cwr: got %h want 04", bus.consumer_write_ready); else n_pass++;
    n_checks++; if (bus.mem_write_valid !== 2'b00) $display("FAIL prec_mwv_low: got %b want 00", bus.mem_write_valid); else n_pass++;
    bus.consumer_write_valid[2] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.consumer_write_ready !== 8'h00) $display("FAIL prec_cwr_rel: got %h want 00", bus.consumer_write_ready); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.consumer_read_address[1] = 8'h44;
    bus.consumer_read_address[6] = 8'h66;
    bus.consumer_read_valid[1]   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b01) $display("FAIL rmid_mrv: got %b want 01", bus.mem_read_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_read_valid !== 2'b00) $display("FAIL rmid_async: got %b want 00", bus.mem_read_valid); else n_pass++;
    n_checks++; if (dut.r_state[0] !== mem_arb_pkg::IDLE) $display("FAIL rmid_state: got %0d want 0", dut.r_state[0]); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.consumer_read_valid[6] = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b11) $display("FAIL rmid_regrant: got %b want 11", bus.mem_read_valid); else n_pass++;
    n_checks++; if (bus.mem_read_address[0] !== 8'h44) $display("FAIL rmid_addr0: got %h want 44", bus.mem_read_address[0]); else n_pass++;
    n_checks++; if (bus.mem_read_address[1] !== 8'h66) $display("FAIL rmid_addr1: got %h want 66", bus.mem_read_address[1]); else n_pass++;
    m_rrdy     = 2'b11;
    m_rdata[0] = 8'h99;
    m_rdata[1] = 8'h98;
    @(negedge clk);
    m_rrdy = 2'b00;
    n_checks++; if (bus.consumer_read_ready !== 8'h42) $display("FAIL rmid_crr: got %h want 42", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (bus.consumer_read_data[1] !== 8'h99) $display("FAIL rmid_data1: got %h want 99", bus.consumer_read_data[1]); else n_pass++;
    n_checks++; if (bus.consumer_read_data[6] !== 8'h98) $display("FAIL rmid_data6: got %h want 98", bus.consumer_read_data[6]); else n_pass++;
    bus.consumer_read_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_busy_stall;
    logic stall_ok;
    do_reset();
    bus.consumer_read_address[0] = 8'h50;
    bus.consumer_read_address[1] = 8'h51;
    bus.consumer_read_address[2] = 8'h52;
    bus.consumer_read_valid[0]   = 1'b1;
    bus.consumer_read_valid[1]   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b11) $display("FAIL stall_both: got %b want 11", bus.mem_read_valid); else n_pass++;
    bus.consumer_read_valid[2] = 1'b1;
    stall_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_read_valid !== 2'b11 || bus.mem_read_address[0] !== 8'h50 ||
          bus.mem_read_address[1] !== 8'h51 || bus.consumer_read_ready !== 8'h00) stall_ok = 1'b0;
    end
    n_checks++; if (stall_ok !== 1'b1) $display("FAIL stall_wait: got %b want 1", stall_ok); else n_pass++;
    m_rrdy     = 2'b01;
    m_rdata[0] = 8'hA0;
    @(negedge clk);
    m_rrdy = 2'b00;
    n_checks++; if (bus.consumer_read_ready !== 8'h01) $display("FAIL stall_crr: got %h want 01", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (bus.consumer_read_data[0] !== 8'hA0) $display("FAIL stall_data: got %h want a0", bus.consumer_read_data[0]); else n_pass++;
    bus.consumer_read_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.consumer_read_ready !== 8'h00) $display("FAIL stall_rel: got %h want 00", bus.consumer_read_ready); else n_pass++;
    n_checks++; if (bus.mem_read_valid !== 2'b10) $display("FAIL stall_gap: got %b want 10", bus.mem_read_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.mem_read_valid !== 2'b11) $display("FAIL stall_grant: got %b want 11", bus.mem_read_valid); else n_pass++;
    n_checks++; if (bus.mem_read_address[0] !== 8'h52) $display("FAIL stall_addr: got %h want 52", bus.mem_read_address[0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_eight_reads();
    test_fairness();
    test_precedence();
    test_reset_mid();
    test_busy_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

Shares a small number of external memory channels between many load/store requesters (one LSU per thread across all cores, or one fetcher per core). Each channel runs an independent request/relay state machine. A round-robin scan picks the next waiting requester for each free channel and forwards its read or write to memory. The response is returned to that requester with a hold-until-release handshake, which is the LSU state (REQUESTING → WAITING → DONE) that the core scheduler's WAIT stage polls.

## Interface
- NUM_CONSUMERS, default 8: number of requesters.
- NUM_CHANNELS, default 2: number of concurrent memory channels; must be 1 ≤ NUM_CHANNELS ≤ NUM_CONSUMERS.
- ADDR_BITS, default 8: address width.
- DATA_BITS, default 8: data width.
- WRITE_ENABLE, default 1: when 0, write ports are tied off and write states are never entered.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- consumer_read_valid  in  [NUM_CONSUMERS]  per-requester read request; held until released.
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address.
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid; held until valid drops.
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned data.
- consumer_write_valid, consumer_write_address, consumer_write_data  in  write request, same shapes as the read request.
- consumer_write_ready  out  [NUM_CONSUMERS]  write acknowledged.
- mem_read_valid  out  [NUM_CHANNELS]; mem_read_address  out  [NUM_CHANNELS][ADDR_BITS].
- mem_read_ready  in  [NUM_CHANNELS]; mem_read_data  in  [NUM_CHANNELS][DATA_BITS].
- mem_write_valid, mem_write_address, mem_write_data  out; mem_write_ready  in  per channel.

## Operation
Each channel has states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING and WRITE_RELAYING. Each channel also owns a `current_consumer` index. A shared `busy_mask[NUM_CONSUMERS]` marks requesters already owned by some channel.

- **IDLE.** Scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS. Take the first one with (read_valid | write_valid) and !busy_mask.
  - Read takes precedence over write for the same consumer.
  - On grant: set busy_mask, latch the index, drive mem_*_valid and the address/data, advance rr_ptr to index+1 (wrapping), then go to *_WAITING.
- **Same-cycle grants.** Channels grant in ascending channel order within a cycle. Channel k sees the busy bits set by channels < k in the same cycle, so no consumer is ever granted twice.
- **READ_WAITING.** Hold mem_read_valid until mem_read_ready. On ready:
  - latch the data into consumer_read_data;
  - assert consumer_read_ready;
  - deassert mem_read_valid;
  - go to READ_RELAYING.
- **WRITE_WAITING.** Same as READ_WAITING, but with no data latch and consumer_write_ready instead.
- **\*_RELAYING.** Hold consumer ready until the consumer's valid is low. Then clear ready and the busy bit, and go to IDLE.
- **Request withdrawal.** A consumer dropping valid during *_WAITING is illegal. The memory transaction completes regardless, and the channel relays then releases once valid is seen low.
- **rr_ptr.** Each channel keeps its own pointer. Pointer arithmetic wraps at NUM_CONSUMERS; for non-power-of-two sizes the wrap is an explicit compare, not truncation.

## Timing
- **Reset (async assert, sync deassert assumed).** All channels go to IDLE; every output, every rr_ptr and busy_mask reset to 0. Any in-flight memory transaction is abandoned.
- **Request to memory.** 1 cycle: consumer valid high at edge N gives mem_*_valid high after edge N+1.
- **Memory response to consumer.** 1 cycle: mem ready sampled at edge M gives consumer ready high and mem valid low after edge M+1.
- **Release.** Consumer valid low sampled at edge R gives consumer ready low after edge R+1. The channel is IDLE and can regrant on edge R+2.
- **Zero-wait memory** (ready asserted in the same cycle as valid): minimum turnaround is 4 cycles per request per channel.
- **All busy.** When all channels are busy, further requests simply wait; requests are never dropped or reordered per consumer.

## Structure
- Package `mem_arb_pkg`: `channel_state_t` enum (IDLE=0, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING) and a consumer-index width helper, $clog2(NUM_CONSUMERS) with a minimum of 1.
- Sub-module `rr_picker`: combinational find-first-set starting from a pointer with wrap, outputting found and index. One instance per channel, fed by the request vector masked with ~busy_mask (including earlier same-cycle grants).
- The top level holds the channel FSM array, busy_mask and the output registers.

## Test plan
- **Single read.** NUM_CHANNELS=2; consumer 3 reads 0x2A; memory returns 0x5C with ready 2 cycles after valid → mem_read_address[0]=0x2A; consumer_read_data[3]=0x5C; ready high until valid drops; channel 0 IDLE 1 cycle later.
- **Eight simultaneous reads.** All 8 consumers read together, memory has 0 wait → channels 0 and 1 take consumers 0 and 1 in the same cycle, never the same index; all 8 complete with correct data; no busy bit left set.
- **Round-robin fairness.** NUM_CHANNELS=1; consumers 0 and 5 re-request continuously → grants alternate 0, 5, 0, 5.
- **Read/write precedence.** Consumer 2 asserts read and write at once → read served first; write granted only after the read releases.
- **Reset mid-operation.** Reset asserted during READ_WAITING → all ready/valid outputs 0 immediately (async); after reset, a fresh request is served normally with rr_ptr=0.
- **Busy stall.** Memory holds ready low for 10 cycles with 2 channels busy → a third requester waits; it is granted exactly 2 cycles after the first channel's release.
